aexm_dcache_resp: RTL
=====================

AEXM_DCACHE_RESP -- requirements
Module: aexm_dcache_resp

Interface
REQ-001 Parameter LINES, default 64, meaning number of direct-mapped one-word lines, power of two, 4..1024; IDX = log2(LINES).
REQ-002 sys_clk_i  input  1  single clock, all state updates on rising edge.
REQ-003 sys_rst_i  input  1  reset, synchronous, active-low.
REQ-004 aexm_dcache_precycle_addr  input  32  CPU byte address, presented one cycle ahead of the access cycle; bits [1:0] ignored.
REQ-005 aexm_dcache_precycle_enable  input  1  request strobe, sampled with addr/we/datao.
REQ-006 aexm_dcache_precycle_we  input  1  1 = full-word write, 0 = read.
REQ-007 aexm_dcache_datao  input  32  CPU store data.
REQ-008 aexm_dcache_force_miss  input  1  treat this read as a miss regardless of tag match.
REQ-009 aexm_dcache_we_tlb  input  1  reserved; ignored.
REQ-010 aexm_dcache_datai  output  32  load data to CPU.
REQ-011 aexm_dcache_cache_busy  output  1  CPU must stall while high.
REQ-012 mem_req  output  1  backing-memory request, held until mem_ack.
REQ-013 mem_we  output  1  backing-memory write qualifier.
REQ-014 mem_addr  output  30  word address (CPU addr[31:2]).
REQ-015 mem_wdata  output  32  write data.
REQ-016 mem_rdata  input  32  read data, valid in the mem_ack cycle.
REQ-017 mem_ack  input  1  one-cycle completion pulse.

Function
REQ-018 Storage: per line valid bit, tag = addr[31:IDX+2], 32-bit data; index = addr[IDX+1:2].
REQ-019 States: IDLE, LOOKUP, MEMWAIT, DONE.
REQ-020 Request capture: at a rising edge where busy=0 and precycle_enable=1, latch addr, we, datao, force_miss; next state LOOKUP; capture allowed from IDLE, LOOKUP-hit and DONE (back-to-back).
REQ-021 Enable while busy=1 is ignored; the CPU holds its request.
REQ-022 LOOKUP, read hit (valid, tag match, force_miss=0): datai = line data registered by end of the cycle, i.e. valid in the following cycle; busy=0 (combinational); next IDLE or LOOKUP per REQ-020.
REQ-023 LOOKUP, read miss or force_miss=1: busy=1 combinationally in LOOKUP; mem_req=1, mem_we=0, mem_addr=addr[31:2] registered for the next cycle; next MEMWAIT.
REQ-024 LOOKUP, write: line updated with datao, tag set, valid=1 (hit or miss, write-allocate without fill); busy=1; mem_req=1, mem_we=1, mem_wdata=datao; next MEMWAIT.
REQ-025 MEMWAIT: busy=1, mem_req/mem_we/mem_addr/mem_wdata stable until mem_ack.
REQ-026 mem_ack in MEMWAIT: mem_req=0 next cycle; for reads, line written with mem_rdata, tag set, valid=1, datai=mem_rdata; for writes datai unchanged; next DONE.
REQ-027 DONE: busy=0 for exactly one cycle; datai valid; new request accepted per REQ-020, else next IDLE.
REQ-028 Latency: read hit data one cycle after LOOKUP; miss: busy high from LOOKUP through the mem_ack cycle; minimum miss is 3 busy cycles (LOOKUP, req, ack-same-cycle not allowed: ack earliest one cycle after mem_req rises).
REQ-029 mem_ack outside MEMWAIT is ignored.
REQ-030 datai holds its last value except updates in REQ-022/REQ-026.
REQ-031 Index wrap: addresses differing only in tag map to the same line; newer fill/write replaces older.

Reset
REQ-032 sys_rst_i=0 at an edge: state IDLE, all valid bits 0, datai=0, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; line data and tags need no reset.
REQ-033 Reset mid-MEMWAIT abandons the transaction: mem_req=0 the next cycle, no line update, a subsequent mem_ack ignored.
REQ-034 Reset dominates simultaneous enable or mem_ack.

Verification
REQ-035 Read 0x100 after reset -> busy 1 in LOOKUP, mem_req with mem_addr=0x40, mem_ack with rdata 0xDEADBEEF -> DONE, datai=0xDEADBEEF, busy 0; repeat read 0x100 -> hit, no mem_req, datai=0xDEADBEEF next cycle.
REQ-036 Write 0x200 data 0x12345678 -> mem_req, mem_we=1, mem_wdata=0x12345678; after ack, read 0x200 hits with 0x12345678, no mem_req.
REQ-037 Alias (LINES=64): fill 0x100, then read 0x200 (same index, different tag) -> miss; read 0x100 again -> miss.
REQ-038 Read 0x100 cached, force_miss=1 -> miss, refill with rdata 0xCAFEF00D, line and datai=0xCAFEF00D.
REQ-039 Reset asserted during MEMWAIT, then mem_ack pulsed -> mem_req 0, no DONE, next read to same address misses.
REQ-040 Back-to-back hits 0x100, 0x104 with enable high two cycles -> busy stays 0, datai sequence matches stored words on consecutive cycles.

Source files
------------

// File: rtl/aexm_dcache_resp.sv
// Direct-mapped, one-word-line write-through data cache for the AEXM core.
// Requests arrive one cycle early (precycle) so the tag check lands in LOOKUP.
module aexm_dcache_resp #(
    parameter int LINES = 64
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic [31:0] aexm_dcache_precycle_addr,
    input  logic        aexm_dcache_precycle_enable,
    input  logic        aexm_dcache_precycle_we,
    input  logic [31:0] aexm_dcache_datao,
    input  logic        aexm_dcache_force_miss,
    input  logic        aexm_dcache_we_tlb,
    output logic [31:0] aexm_dcache_datai,
    output logic        aexm_dcache_cache_busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = 30 - IDX;

    typedef enum logic [1:0] {IDLE, LOOKUP, MEMWAIT, DONE} state_t;

    state_t             state;
    logic [29:0]        waddr_q;
    logic               we_q;
    logic [31:0]        wdata_q;
    logic               force_q;
    logic [LINES-1:0]   valid;
    logic [31:0]        line_data [LINES];
    logic [TAG_W-1:0]   line_tag  [LINES];

    logic [IDX-1:0]     idx;
    logic [TAG_W-1:0]   tag;
    logic               read_hit;
    logic               capture;
    logic               line_wr;
    logic               unused;

    assign unused   = ^{aexm_dcache_we_tlb, aexm_dcache_precycle_addr[1:0]};
    assign idx      = waddr_q[IDX-1:0];
    assign tag      = waddr_q[29:IDX];
    assign read_hit = !we_q && !force_q && valid[idx] && (line_tag[idx] == tag);

    always_comb begin
        aexm_dcache_cache_busy = 1'b0;
        if (state == MEMWAIT || (state == LOOKUP && !read_hit))
            aexm_dcache_cache_busy = 1'b1;
    end

    assign capture = !aexm_dcache_cache_busy && aexm_dcache_precycle_enable;

    // Writes allocate in LOOKUP; read misses fill on the ack.
    assign line_wr = (state == LOOKUP && we_q) || (state == MEMWAIT && mem_ack && !we_q);

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i && line_wr) begin
            line_data[idx] <= we_q ? wdata_q : mem_rdata;
            line_tag[idx]  <= tag;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            state             <= IDLE;
            valid             <= '0;
            aexm_dcache_datai <= '0;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= '0;
            mem_wdata         <= '0;
            waddr_q           <= '0;
            we_q              <= 1'b0;
            wdata_q           <= '0;
            force_q           <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= IDLE;
                LOOKUP: begin
                    if (read_hit) begin
                        aexm_dcache_datai <= line_data[idx];
                        state             <= IDLE;
                    end else begin
                        mem_req   <= 1'b1;
                        mem_we    <= we_q;
                        mem_addr  <= waddr_q;
                        mem_wdata <= wdata_q;
                        state     <= MEMWAIT;
                        if (we_q)
                            valid[idx] <= 1'b1;
                    end
                end
                MEMWAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                        if (!we_q) begin
                            valid[idx]        <= 1'b1;
                            aexm_dcache_datai <= mem_rdata;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
            // A new request overrides the default next state above.
            if (capture) begin
                waddr_q <= aexm_dcache_precycle_addr[31:2];
                we_q    <= aexm_dcache_precycle_we;
                wdata_q <= aexm_dcache_datao;
                force_q <= aexm_dcache_force_miss;
                state   <= LOOKUP;
            end
        end
    end
endmodule
